// File: rtl/lab5_fetch.sv
// lab5_fetch: instruction fetch stage for the lab 5 16-bit CPU.
// Owns the PC, drives the byte address into the 128x16 instruction memory
// (combinational read), and captures each word into the IF/ID register.
// Handles decode stalls, execute-stage redirects/flushes and HALT detection.
//
// Flow control: the IF/ID register is offered to decode with o_valid; decode
// applies backpressure by raising i_stall, which freezes the whole stage
// (PC, IF/ID, counter). A redirect (i_br_taken) overrides a stall, and a
// stall overrides the halt bookkeeping. o_iaddr depends on the PC register
// only, so there is no combinational path from i_stall or i_br_taken.
module lab5_fetch #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [15:0] HALT_WORD = 16'h0001
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [7:0]  o_iaddr,
  input  logic [15:0] i_idata,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [7:0]  i_br_target,
  output logic [15:0] o_instr_out,
  output logic [7:0]  o_pc_out,
  output logic        o_valid,
  output logic        o_halted,
  output logic [15:0] o_fetch_count,
  output logic        o_dbg_state
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_pc;
  logic [15:0] r_instr;
  logic [7:0]  r_pc_out;
  logic        r_valid;
  logic [15:0] r_count;

  logic [7:0]  w_pc_nxt;
  logic [15:0] w_instr_nxt;
  logic [7:0]  w_pc_out_nxt;
  logic        w_valid_nxt;
  logic [15:0] w_count_nxt;
  logic [7:0]  w_pc_plus2;
  logic        w_is_halt;

  // PC arithmetic wraps modulo 256, so 8'hFE + 2 lands on 8'h00.
  assign w_pc_plus2 = r_pc + 8'd2;
  assign w_is_halt  = (i_idata == HALT_WORD);

  // State register: RUN fetches, HALT parks the PC on the HALT word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decisions: branch > stall > halt > fetch.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_pc_out_nxt = r_pc_out;
    w_valid_nxt  = r_valid;
    w_count_nxt  = r_count;
    if (i_br_taken) begin
      // Flush IF/ID; any HALT sitting there is younger than the branch.
      w_pc_nxt    = {i_br_target[7:1], 1'b0};
      w_valid_nxt = 1'b0;
      w_state_nxt = ST_RUN;
    end else if (i_stall) begin
      // Hold everything.
    end else if (r_state == ST_HALT) begin
      // The HALT word was presented for one cycle; retire it.
      w_valid_nxt = 1'b0;
    end else begin
      w_instr_nxt  = i_idata;
      w_pc_out_nxt = w_pc_plus2;
      w_valid_nxt  = 1'b1;
      w_count_nxt  = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
      if (w_is_halt) begin
        w_state_nxt = ST_HALT;
      end else begin
        w_pc_nxt = w_pc_plus2;
      end
    end
  end

  // PC, IF/ID register and fetch counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc     <= {RESET_PC[7:1], 1'b0};
      r_instr  <= 16'h0000;
      r_pc_out <= 8'h00;
      r_valid  <= 1'b0;
      r_count  <= 16'h0000;
    end else begin
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_valid  <= w_valid_nxt;
      r_count  <= w_count_nxt;
    end
  end

  assign o_iaddr       = r_pc;
  assign o_instr_out   = r_instr;
  assign o_pc_out      = r_pc_out;
  assign o_valid       = r_valid;
  assign o_halted      = (r_state == ST_HALT);
  assign o_fetch_count = r_count;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_lab5_fetch.sv
// Directed bench for lab5_fetch with a combinational 128x16 instruction
// memory model. Every expected value below is hand-derived from the program.
module tb_lab5_fetch;

  logic        clk;
  logic        rst_n;
  logic [7:0]  iaddr;
  logic [15:0] idata;
  logic        stall;
  logic        br_taken;
  logic [7:0]  br_target;
  logic [15:0] instr_out;
  logic [7:0]  pc_out;
  logic        valid;
  logic        halted;
  logic [15:0] fetch_count;
  logic        dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mem [128];

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory loads its program on its own synchronous reset (shared with DUT).
  // Word i holds 16'hA000+i, except word 11 (byte 0x16) holds HALT.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= 16'hA000 + 16'(i);
      mem[11] <= 16'h0001;
    end
  end

  assign idata = mem[iaddr[7:1]];

  lab5_fetch dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_iaddr       (iaddr),
    .i_idata       (idata),
    .i_stall       (stall),
    .i_br_taken    (br_taken),
    .i_br_target   (br_target),
    .o_instr_out   (instr_out),
    .o_pc_out      (pc_out),
    .o_valid       (valid),
    .o_halted      (halted),
    .o_fetch_count (fetch_count),
    .o_dbg_state   (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [15:0] e_instr,
                          input logic [7:0] e_pc_out, input logic e_valid,
                          input logic [7:0] e_iaddr, input logic [15:0] e_cnt);
    check({tag, ".instr"}, 32'(instr_out), 32'(e_instr));
    check({tag, ".pc_out"}, 32'(pc_out), 32'(e_pc_out));
    check({tag, ".valid"}, 32'(valid), 32'(e_valid));
    check({tag, ".iaddr"}, 32'(iaddr), 32'(e_iaddr));
    check({tag, ".count"}, 32'(fetch_count), 32'(e_cnt));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".iaddr"}, 32'(iaddr), 32'h00);
    check({tag, ".instr"}, 32'(instr_out), 32'h0000);
    check({tag, ".pc_out"}, 32'(pc_out), 32'h00);
    check({tag, ".valid"}, 32'(valid), 32'h0);
    check({tag, ".halted"}, 32'(halted), 32'h0);
    check({tag, ".count"}, 32'(fetch_count), 32'h0000);
  endtask

  initial begin
    rst_n     = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    // Sequential fetch.
    step(); check_if("seq0", 16'hA000, 8'h02, 1'b1, 8'h02, 16'd1);
    step(); check_if("seq1", 16'hA001, 8'h04, 1'b1, 8'h04, 16'd2);

    // Stall for three cycles with A1 in IF/ID.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); check_if("stall", 16'hA001, 8'h04, 1'b1, 8'h04, 16'd2);
    end
    stall = 1'b0;
    step(); check_if("seq2", 16'hA002, 8'h06, 1'b1, 8'h06, 16'd3);
    step(); check_if("seq3", 16'hA003, 8'h08, 1'b1, 8'h08, 16'd4);

    // Branch to 0x13 (bit 0 dropped -> 0x12) while IADDR = 0x08.
    br_taken = 1'b1; br_target = 8'h13;
    step();
    br_taken = 1'b0;
    check("br1.iaddr", 32'(iaddr), 32'h12);
    check("br1.valid", 32'(valid), 32'h0);
    check("br1.count", 32'(fetch_count), 32'd4);
    step(); check_if("br1.tgt", 16'hA009, 8'h14, 1'b1, 8'h14, 16'd5);
    step(); check_if("seq10", 16'hA00A, 8'h16, 1'b1, 8'h16, 16'd6);

    // HALT word at 0x16.
    step(); check_if("halt", 16'h0001, 8'h18, 1'b1, 8'h16, 16'd7);
    check("halt.halted", 32'(halted), 32'h1);
    check("halt.dbg", 32'(dbg_state), 32'h1);
    step(); check_if("halt+1", 16'h0001, 8'h18, 1'b0, 8'h16, 16'd7);
    repeat (10) step();
    check_if("halt+11", 16'h0001, 8'h18, 1'b0, 8'h16, 16'd7);
    check("halt+11.halted", 32'(halted), 32'h1);

    // Redirect out of the halted state.
    br_taken = 1'b1; br_target = 8'h00;
    step();
    br_taken = 1'b0;
    check("unhalt.halted", 32'(halted), 32'h0);
    check("unhalt.iaddr", 32'(iaddr), 32'h00);
    check("unhalt.valid", 32'(valid), 32'h0);
    step(); check_if("re0", 16'hA000, 8'h02, 1'b1, 8'h02, 16'd8);
    step(); step(); step();
    check_if("re3", 16'hA003, 8'h08, 1'b1, 8'h08, 16'd11);

    // Branch and stall together: branch wins.
    br_taken = 1'b1; stall = 1'b1; br_target = 8'h13;
    step();
    br_taken = 1'b0; stall = 1'b0;
    check("br2.iaddr", 32'(iaddr), 32'h12);
    check("br2.valid", 32'(valid), 32'h0);
    check("br2.count", 32'(fetch_count), 32'd11);
    step(); check_if("br2.tgt", 16'hA009, 8'h14, 1'b1, 8'h14, 16'd12);
    step(); step();
    check_if("halt2", 16'h0001, 8'h18, 1'b1, 8'h16, 16'd14);
    check("halt2.halted", 32'(halted), 32'h1);

    // HALT in IF/ID squashed by a same-cycle branch to 0x00.
    br_taken = 1'b1; br_target = 8'h00;
    step();
    br_taken = 1'b0;
    check("squash.halted", 32'(halted), 32'h0);
    check("squash.iaddr", 32'(iaddr), 32'h00);
    check("squash.valid", 32'(valid), 32'h0);
    check("squash.count", 32'(fetch_count), 32'd14);
    step(); check_if("squash.re", 16'hA000, 8'h02, 1'b1, 8'h02, 16'd15);

    // PC wrap: branch to 0xFF (-> 0xFE), then fetch wraps to 0x00.
    br_taken = 1'b1; br_target = 8'hFF;
    step();
    br_taken = 1'b0;
    check("wrap.iaddr", 32'(iaddr), 32'hFE);
    check("wrap.valid", 32'(valid), 32'h0);
    step(); check_if("wrap", 16'hA07F, 8'h00, 1'b1, 8'h00, 16'd16);
    step(); check_if("wrap+1", 16'hA000, 8'h02, 1'b1, 8'h02, 16'd17);

    // Mid-cycle async reset with a redirect in flight.
    #2;
    br_taken = 1'b1; br_target = 8'h40;
    rst_n = 1'b0;
    #1;
    check_reset("async");
    step();
    br_taken = 1'b0;
    check_reset("async.held");
    rst_n = 1'b1;
    step(); check_if("post", 16'hA000, 8'h02, 1'b1, 8'h02, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lab5_fetch.md
# lab5_fetch

Instruction fetch stage of the lab 5 single-issue 16-bit CPU. It owns the program counter and drives the byte address into the 128×16 instruction memory, which returns its word combinationally. Each fetched word is captured into the IF/ID pipeline register for the decode stage. It also handles decode stalls, execute-stage branch redirects/flushes and HALT detection.

## Interface
- RESET_PC, 8'h00, byte address loaded into PC on reset (bit 0 ignored)
- HALT_WORD, 16'h0001, encoding that stops fetch
- CLK  in  1  system clock, all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- IADDR  out  8  byte address to instruction memory; equals PC
- IDATA  in  16  instruction word from memory (combinational on IADDR)
- STALL  in  1  decode cannot accept; hold PC and IF/ID register
- BR_TAKEN  in  1  execute-stage redirect request, single-cycle pulse
- BR_TARGET  in  8  redirect byte address (bit 0 forced to 0)
- INSTR_OUT  out  16  IF/ID instruction
- PC_OUT  out  8  IF/ID PC+2 of that instruction (branch base)
- VALID  out  1  IF/ID holds a real instruction
- HALTED  out  1  fetch stopped on HALT_WORD
- FETCH_COUNT  out  16  number of instructions accepted into IF/ID, saturating

## Operation
- Registers: PC[7:0], INSTR_OUT, PC_OUT, VALID, HALTED, FETCH_COUNT. PC[0] is always 0.
- States: RUN (HALTED=0), HALT (HALTED=1).
- Priority per rising edge: BR_TAKEN > STALL > HALT > normal fetch.
- BR_TAKEN=1, any state:
  - PC <= {BR_TARGET[7:1],0}.
  - VALID <= 0 (flush), HALTED <= 0.
  - FETCH_COUNT unchanged.
  - A HALT already sitting in IF/ID is younger than the branch and is squashed.
- STALL=1, BR_TAKEN=0: all registers hold.
- HALT, no branch: PC, IF/ID, FETCH_COUNT hold. VALID <= 0 after the HALT word has been presented for one cycle.
- RUN, no stall, no branch:
  - INSTR_OUT <= IDATA, PC_OUT <= PC+2, VALID <= 1.
  - FETCH_COUNT <= FETCH_COUNT+1, saturating at 16'hFFFF.
  - If IDATA == HALT_WORD: HALTED <= 1 and PC holds (points at the HALT). Otherwise PC <= PC+2.
- PC arithmetic is 8-bit modulo: 8'hFE + 2 = 8'h00. PC_OUT wraps the same way.
- Instruction memory loads its program on its own synchronous reset. The bench must hold RESET_N low across at least one CLK edge and keep the memory reset asserted over the same window.

## Timing
- Reset (async, immediate, independent of CLK):
  - PC = RESET_PC with bit 0 cleared.
  - INSTR_OUT = 0, PC_OUT = 0, VALID = 0, HALTED = 0, FETCH_COUNT = 0.
- First fetch is captured on the first rising edge after RESET_N rises.
- Latency: IADDR = PC in cycle N; INSTR_OUT/VALID reflect that word in cycle N+1. Throughput is one instruction per cycle.
- IADDR is a pure function of PC: no combinational path from STALL or BR_TAKEN.
- Branch penalty: the word in IF/ID during the BR_TAKEN cycle is discarded. The target word appears in IF/ID two edges after the BR_TAKEN edge, with a VALID=0 bubble between.
- Simultaneous STALL and BR_TAKEN: the branch wins and the flush happens.
- Reset asserted mid-cycle: all outputs take reset values immediately, and any in-flight redirect is lost.

## Test plan
- Sequential fetch, memory words A0..A3 at 0x00..0x06 -> INSTR_OUT = A0,A1,A2,A3 on consecutive cycles. PC_OUT = 0x02,0x04,0x06,0x08. FETCH_COUNT = 4.
- STALL high 3 cycles with A1 in IF/ID -> INSTR_OUT=A1, IADDR=0x04 for 3 cycles. Fetch resumes with A2, no duplicate or skip, FETCH_COUNT counts A1 once.
- BR_TAKEN with BR_TARGET=0x13 while IADDR=0x08 -> next IADDR=0x12, VALID=0 one cycle, then INSTR_OUT=mem[9]. Repeat with STALL=1 simultaneously -> same result.
- HALT_WORD at 0x16 -> HALTED=1 one edge after IADDR=0x16. IADDR stays 0x16, VALID falls one cycle later, FETCH_COUNT frozen for ≥10 cycles.
- HALT in IF/ID plus BR_TAKEN to 0x00 in the same cycle -> HALTED=0, IADDR=0x00, fetch resumes.
- PC at 0xFE, non-halt word -> next IADDR=0x00, PC_OUT=0x00. RESET_N pulsed low mid-run between edges -> all outputs return to reset values without a CLK edge.
